// File: rtl/che_cmf_fch_pkg.sv
// Shared geometry, widths and corner-slot encoding for the CMF fetch stage.
// Tile-index arithmetic lives here so the top and the bench model agree on {ty, tx} packing.
package che_cmf_fch_pkg;

    localparam int DAT_PIX_WD = 8;
    localparam int TILE_SIZ   = 64;
    localparam int TILE_NUM_X = 4;
    localparam int TILE_NUM_Y = 4;

    localparam int TW      = $clog2(TILE_SIZ);
    localparam int HALF    = TILE_SIZ / 2;
    localparam int IMG_WID = TILE_NUM_X * TILE_SIZ;
    localparam int IMG_HEI = TILE_NUM_Y * TILE_SIZ;
    localparam int IW      = $clog2(TILE_NUM_X * TILE_NUM_Y);
    localparam int XW      = $clog2(TILE_NUM_X);
    localparam int YW      = $clog2(TILE_NUM_Y);
    localparam int ADR_WD  = IW + DAT_PIX_WD;

    typedef enum logic [1:0] {
        SLOT_UL = 2'd0,
        SLOT_UR = 2'd1,
        SLOT_BL = 2'd2,
        SLOT_BR = 2'd3
    } slot_e;

    function automatic logic [IW-1:0] tile_idx(input logic [YW-1:0] ty, input logic [XW-1:0] tx);
        return IW'(ty) * IW'(TILE_NUM_X) + IW'(tx);
    endfunction

endpackage

// File: rtl/che_cmf_fch_if.sv
// Pixel-in, CMF-RAM and corner-out signal bundle of the CMF fetch stage.
interface che_cmf_fch_if;
    import che_cmf_fch_pkg::*;

    // vld_i is a strobe with no ready: every valid pixel is accepted in its cycle.
    logic                  vld_i;
    logic                  fst_i;
    logic [DAT_PIX_WD-1:0] dat_i;

    logic                  cmf_rd_en_o;
    logic [ADR_WD-1:0]     cmf_ul_adr_o;
    logic [ADR_WD-1:0]     cmf_ur_adr_o;
    logic [ADR_WD-1:0]     cmf_bl_adr_o;
    logic [ADR_WD-1:0]     cmf_br_adr_o;
    logic [DAT_PIX_WD-1:0] cmf_ul_rdat_i;
    logic [DAT_PIX_WD-1:0] cmf_ur_rdat_i;
    logic [DAT_PIX_WD-1:0] cmf_bl_rdat_i;
    logic [DAT_PIX_WD-1:0] cmf_br_rdat_i;

    logic                  ul_vld_o;
    logic                  ur_vld_o;
    logic                  bl_vld_o;
    logic                  br_vld_o;
    logic [DAT_PIX_WD-1:0] ul_dat_o;
    logic [DAT_PIX_WD-1:0] ur_dat_o;
    logic [DAT_PIX_WD-1:0] bl_dat_o;
    logic [DAT_PIX_WD-1:0] br_dat_o;
    logic [TW-1:0]         pos_x_o;
    logic [TW-1:0]         pos_y_o;

    modport master (
        output vld_i, fst_i, dat_i,
        output cmf_ul_rdat_i, cmf_ur_rdat_i, cmf_bl_rdat_i, cmf_br_rdat_i,
        input  cmf_rd_en_o, cmf_ul_adr_o, cmf_ur_adr_o, cmf_bl_adr_o, cmf_br_adr_o,
        input  ul_vld_o, ur_vld_o, bl_vld_o, br_vld_o,
        input  ul_dat_o, ur_dat_o, bl_dat_o, br_dat_o,
        input  pos_x_o, pos_y_o
    );

    modport slave (
        input  vld_i, fst_i, dat_i,
        input  cmf_ul_rdat_i, cmf_ur_rdat_i, cmf_bl_rdat_i, cmf_br_rdat_i,
        output cmf_rd_en_o, cmf_ul_adr_o, cmf_ur_adr_o, cmf_bl_adr_o, cmf_br_adr_o,
        output ul_vld_o, ur_vld_o, bl_vld_o, br_vld_o,
        output ul_dat_o, ur_dat_o, bl_dat_o, br_dat_o,
        output pos_x_o, pos_y_o
    );

endinterface

// File: rtl/che_cmf_fch_axs.sv
// Per-axis resolver: tracks coordinate c as (c + HALF) split into a tile counter and an
// in-tile position, so near/far tiles and the weight fall out without any divider.
module che_cmf_axs
    import che_cmf_fch_pkg::*;
#(
    parameter int NUM = 4,
    parameter int AW  = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          step,
    input  logic          clr,
    output logic [AW-1:0] near,
    output logic [AW-1:0] far,
    output logic          far_vld,
    output logic [TW-1:0] pos,
    output logic          last
);
    localparam int TCW = $clog2(NUM + 1);

    logic [TW-1:0]  pos_r;
    logic [TCW-1:0] tile_r;
    logic [TW-1:0]  cur_pos;
    logic [TCW-1:0] cur_tile;
    logic           mid;

    // A first-pixel marker overrides the stored state for this very pixel.
    assign cur_pos  = clr ? TW'(HALF) : pos_r;
    assign cur_tile = clr ? '0 : tile_r;

    // Tile 0 is the leading half tile, tile NUM the trailing one; both are single-tile.
    assign mid     = (cur_tile != '0) && (cur_tile != TCW'(NUM));
    assign last    = (cur_tile == TCW'(NUM)) && (cur_pos == TW'(HALF - 1));
    assign near    = (cur_tile == '0) ? '0 : AW'(cur_tile - TCW'(1));
    assign far     = mid ? AW'(cur_tile) : '0;
    assign far_vld = mid;
    assign pos     = mid ? cur_pos : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pos_r  <= '0;
            tile_r <= '0;
        end else if (step) begin
            if (last) begin
                pos_r  <= TW'(HALF);
                tile_r <= '0;
            end else begin
                pos_r  <= cur_pos + TW'(1);
                tile_r <= (&cur_pos) ? cur_tile + TCW'(1) : cur_tile;
            end
        end else if (clr) begin
            pos_r  <= cur_pos;
            tile_r <= cur_tile;
        end
    end

endmodule

// File: rtl/che_cmf_fch.sv
// CMF fetch stage: resolves the surrounding tiles of each pixel, reads their CMF values
// and presents corner valids/data with pos_x at N+2 and pos_y at N+3.
module che_cmf_fch
    import che_cmf_fch_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    che_cmf_fch_if.slave bus
);
    logic          take;
    logic          first;
    logic [XW-1:0] x_near, x_far;
    logic [YW-1:0] y_near, y_far;
    logic          x_far_vld, y_far_vld, x_last, y_last_unused;
    logic [TW-1:0] x_pos, y_pos;

    assign take  = bus.vld_i;
    assign first = bus.vld_i & bus.fst_i;

    che_cmf_axs #(.NUM(TILE_NUM_X), .AW(XW)) u_axs_x (
        .clk(clk), .rstn(rstn), .step(take), .clr(first),
        .near(x_near), .far(x_far), .far_vld(x_far_vld), .pos(x_pos), .last(x_last)
    );

    che_cmf_axs #(.NUM(TILE_NUM_Y), .AW(YW)) u_axs_y (
        .clk(clk), .rstn(rstn), .step(take & x_last), .clr(first),
        .near(y_near), .far(y_far), .far_vld(y_far_vld), .pos(y_pos), .last(y_last_unused)
    );

    // Single column/row always lands in the left/up slot, so ur/br imply ul/bl.
    logic [3:0] vld_n;
    always_comb begin
        vld_n          = '0;
        vld_n[SLOT_UL] = take;
        vld_n[SLOT_UR] = take & x_far_vld;
        vld_n[SLOT_BL] = take & y_far_vld;
        vld_n[SLOT_BR] = take & x_far_vld & y_far_vld;
    end

    logic [ADR_WD-1:0] adr_ul, adr_ur, adr_bl, adr_br;
    logic              rd_en;
    logic [3:0]        vld1, vld2;
    logic [TW-1:0]     px1, py1, px2, py2, py3;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_en  <= 1'b0;
            adr_ul <= '0;
            adr_ur <= '0;
            adr_bl <= '0;
            adr_br <= '0;
            vld1   <= '0;
            px1    <= '0;
            py1    <= '0;
        end else begin
            rd_en  <= take;
            vld1   <= vld_n;
            adr_ul <= vld_n[SLOT_UL] ? {tile_idx(y_near, x_near), bus.dat_i} : '0;
            adr_ur <= vld_n[SLOT_UR] ? {tile_idx(y_near, x_far),  bus.dat_i} : '0;
            adr_bl <= vld_n[SLOT_BL] ? {tile_idx(y_far,  x_near), bus.dat_i} : '0;
            adr_br <= vld_n[SLOT_BR] ? {tile_idx(y_far,  x_far),  bus.dat_i} : '0;
            if (take) begin
                px1 <= x_pos;
                py1 <= y_pos;
            end
        end
    end

    // pos_y trails by one more stage to meet the interpolator's second multiply.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld2 <= '0;
            px2  <= '0;
            py2  <= '0;
            py3  <= '0;
        end else begin
            vld2 <= vld1;
            if (vld1[SLOT_UL]) begin
                px2 <= px1;
                py2 <= py1;
            end
            if (vld2[SLOT_UL]) begin
                py3 <= py2;
            end
        end
    end

    assign bus.cmf_rd_en_o  = rd_en;
    assign bus.cmf_ul_adr_o = adr_ul;
    assign bus.cmf_ur_adr_o = adr_ur;
    assign bus.cmf_bl_adr_o = adr_bl;
    assign bus.cmf_br_adr_o = adr_br;

    assign bus.ul_vld_o = vld2[SLOT_UL];
    assign bus.ur_vld_o = vld2[SLOT_UR];
    assign bus.bl_vld_o = vld2[SLOT_BL];
    assign bus.br_vld_o = vld2[SLOT_BR];
    assign bus.ul_dat_o = bus.cmf_ul_rdat_i;
    assign bus.ur_dat_o = bus.cmf_ur_rdat_i;
    assign bus.bl_dat_o = bus.cmf_bl_rdat_i;
    assign bus.br_dat_o = bus.cmf_br_rdat_i;
    assign bus.pos_x_o  = px2;
    assign bus.pos_y_o  = py3;

endmodule

// File: tb/tb_che_cmf_fch.sv
// Bench for che_cmf_fch: reference tile resolver, CMF RAM model and expected queues for the
// address stage (N+1), corner stage (N+2) and pos_y stage (N+3).
module tb_che_cmf_fch;
  import che_cmf_fch_pkg::*;

  localparam int EW = 65;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  che_cmf_fch_if bus();
  che_cmf_fch dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  int mx = 0;
  int my = 0;

  logic [EW-1:0] exp_adr_q[$];
  logic [EW-1:0] exp_out_q[$];

  function automatic logic [7:0] ram_f(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
  endfunction

  // CMF RAM model: one-cycle read latency on all four ports.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.cmf_ul_rdat_i <= '0;
      bus.cmf_ur_rdat_i <= '0;
      bus.cmf_bl_rdat_i <= '0;
      bus.cmf_br_rdat_i <= '0;
    end else if (bus.cmf_rd_en_o) begin
      bus.cmf_ul_rdat_i <= ram_f(bus.cmf_ul_adr_o);
      bus.cmf_ur_rdat_i <= ram_f(bus.cmf_ur_adr_o);
      bus.cmf_bl_rdat_i <= ram_f(bus.cmf_bl_adr_o);
      bus.cmf_br_rdat_i <= ram_f(bus.cmf_br_adr_o);
    end
  end

  function automatic void resolve(input int c, input int n, output int near, output int far,
                                  output int fv, output int pos);
    int t;
    near = 0; far = 0; fv = 0; pos = 0;
    if (c >= 32) begin
      t = (c - 32) / 64;
      near = t;
      if (t < n - 1) begin
        far = t + 1;
        fv = 1;
        pos = (c - 32) % 64;
      end
    end
  endfunction

  // Hand-derived constants for the directed pixels: {adr ul,ur,bl,br, vld ul,ur,bl,br, px, py}.
  function automatic logic [63:0] dir_exp(input logic [15:0] c);
    case (c)
      16'h0000:        return {12'h010, 12'h000, 12'h000, 12'h000, 4'b1000, 6'd0, 6'd0};
      {8'd100, 8'd100}: return {12'h5A0, 12'h6A0, 12'h9A0, 12'hAA0, 4'b1111, 6'd4, 6'd4};
      {8'd240, 8'd40}:  return {12'h355, 12'h000, 12'h755, 12'h000, 4'b1010, 6'd0, 6'd8};
      default:         return '0;
    endcase
  endfunction

  task automatic drive(input logic v, input logic f, input logic [7:0] d, input logic dir);
    int xn, xf, xv, px, yn, yf, yv, py;
    logic [11:0] a_ul, a_ur, a_bl, a_br;
    logic [3:0] ev;
    logic [15:0] coord;
    @(posedge clk);
    #1;
    bus.vld_i = v;
    bus.fst_i = v & f;
    bus.dat_i = d;
    if (v) begin
      if (f) begin
        mx = 0;
        my = 0;
      end
      resolve(mx, TILE_NUM_X, xn, xf, xv, px);
      resolve(my, TILE_NUM_Y, yn, yf, yv, py);
      a_ul = {4'(yn * 4 + xn), d};
      a_ur = (xv != 0) ? {4'(yn * 4 + xf), d} : 12'h000;
      a_bl = (yv != 0) ? {4'(yf * 4 + xn), d} : 12'h000;
      a_br = (xv != 0 && yv != 0) ? {4'(yf * 4 + xf), d} : 12'h000;
      ev = {1'b1, xv != 0, yv != 0, xv != 0 && yv != 0};
      coord = {8'(mx), 8'(my)};
      exp_adr_q.push_back({dir, coord, a_ul, a_ur, a_bl, a_br});
      exp_out_q.push_back({dir, coord, ev, ram_f(a_ul), ram_f(a_ur), ram_f(a_bl), ram_f(a_br),
                           6'(px), 6'(py)});
      mx = mx + 1;
      if (mx == IMG_WID) begin
        mx = 0;
        my = (my == IMG_HEI - 1) ? 0 : my + 1;
      end
    end
  endtask

  // Monitor: address stage, corner stage, then pos_y one cycle after each corner beat.
  logic [EW-1:0] ea, eo;
  logic [63:0]   dx;
  logic          py_pend = 1'b0;
  logic          py_dir = 1'b0;
  logic [5:0]    py_exp, py_dexp;
  logic [3:0]    ov, mk;
  logic [31:0]   od, m32;

  always @(negedge clk) begin
    if (!rstn) begin
      py_pend = 1'b0;
    end else begin
      if (py_pend) begin
        checks++;
        assert (bus.pos_y_o === py_exp) else begin
          failures++;
          $error("FAIL pos_y obs=%0d exp=%0d", bus.pos_y_o, py_exp);
        end
        if (py_dir) begin
          checks++;
          assert (bus.pos_y_o === py_dexp) else begin
            failures++;
            $error("FAIL dir_pos_y obs=%0d exp=%0d", bus.pos_y_o, py_dexp);
          end
        end
        py_pend = 1'b0;
      end
      if (bus.cmf_rd_en_o) begin
        checks++;
        assert (exp_adr_q.size() != 0) else begin
          failures++;
          $error("FAIL adr_unexpected obs=rd_en exp=idle");
        end
        if (exp_adr_q.size() != 0) begin
          ea = exp_adr_q.pop_front();
          checks++;
          assert ({bus.cmf_ul_adr_o, bus.cmf_ur_adr_o, bus.cmf_bl_adr_o, bus.cmf_br_adr_o} === ea[47:0])
          else begin
            failures++;
            $error("FAIL adr obs=%h exp=%h",
                   {bus.cmf_ul_adr_o, bus.cmf_ur_adr_o, bus.cmf_bl_adr_o, bus.cmf_br_adr_o}, ea[47:0]);
          end
          if (ea[64]) begin
            dx = dir_exp(ea[63:48]);
            checks++;
            assert ({bus.cmf_ul_adr_o, bus.cmf_ur_adr_o, bus.cmf_bl_adr_o, bus.cmf_br_adr_o} === dx[63:16])
            else begin
              failures++;
              $error("FAIL dir_adr obs=%h exp=%h",
                     {bus.cmf_ul_adr_o, bus.cmf_ur_adr_o, bus.cmf_bl_adr_o, bus.cmf_br_adr_o}, dx[63:16]);
            end
          end
        end
      end
      ov = {bus.ul_vld_o, bus.ur_vld_o, bus.bl_vld_o, bus.br_vld_o};
      if (ov != 4'b0000) begin
        checks++;
        assert (!(bus.ur_vld_o && !bus.ul_vld_o) && !(bus.br_vld_o && !bus.bl_vld_o)) else begin
          failures++;
          $error("FAIL slot_rule obs=%b exp=ur->ul,br->bl", ov);
        end
        checks++;
        assert (exp_out_q.size() != 0) else begin
          failures++;
          $error("FAIL out_unexpected obs=%b exp=none", ov);
        end
        if (exp_out_q.size() != 0) begin
          eo = exp_out_q.pop_front();
          n_out++;
          checks++;
          assert (ov === eo[47:44]) else begin
            failures++;
            $error("FAIL vld obs=%b exp=%b", ov, eo[47:44]);
          end
          mk = eo[47:44];
          m32 = {{8{mk[3]}}, {8{mk[2]}}, {8{mk[1]}}, {8{mk[0]}}};
          od = {bus.ul_dat_o, bus.ur_dat_o, bus.bl_dat_o, bus.br_dat_o};
          checks++;
          assert ((od & m32) === (eo[43:12] & m32)) else begin
            failures++;
            $error("FAIL dat obs=%h exp=%h", od & m32, eo[43:12] & m32);
          end
          checks++;
          assert (bus.pos_x_o === eo[11:6]) else begin
            failures++;
            $error("FAIL pos_x obs=%0d exp=%0d", bus.pos_x_o, eo[11:6]);
          end
          py_pend = 1'b1;
          py_exp = eo[5:0];
          py_dir = eo[64];
          if (eo[64]) begin
            dx = dir_exp(eo[63:48]);
            py_dexp = dx[5:0];
            checks++;
            assert ({ov, bus.pos_x_o} === dx[15:6]) else begin
              failures++;
              $error("FAIL dir_vld_posx obs=%h exp=%h", {ov, bus.pos_x_o}, dx[15:6]);
            end
          end
        end
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 20 && (exp_adr_q.size() != 0 || exp_out_q.size() != 0 || py_pend); k++)
      @(negedge clk);
    @(negedge clk);
    checks++;
    assert (exp_adr_q.size() == 0 && exp_out_q.size() == 0 && !py_pend) else begin
      failures++;
      $error("FAIL drain_timeout obs=%0d/%0d pending exp=0", exp_adr_q.size(), exp_out_q.size());
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [96:0] o;
    o = {bus.cmf_rd_en_o, bus.cmf_ul_adr_o, bus.cmf_ur_adr_o, bus.cmf_bl_adr_o, bus.cmf_br_adr_o,
         bus.ul_vld_o, bus.ur_vld_o, bus.bl_vld_o, bus.br_vld_o,
         bus.ul_dat_o, bus.ur_dat_o, bus.bl_dat_o, bus.br_dat_o, bus.pos_x_o, bus.pos_y_o};
    checks++;
    assert (o === '0) else begin
      failures++;
      $error("FAIL %s obs=%h exp=0", tag, o);
    end
  endtask

  int n0;
  logic rv;

  initial begin
    bus.vld_i = 1'b0;
    bus.fst_i = 1'b0;
    bus.dat_i = '0;
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk);
    #2 rstn = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Full gapless frame with directed pixels at (0,0), (100,100), (240,40).
    n0 = n_out;
    drive(1'b1, 1'b1, 8'h10, 1'b1);
    for (int i = 1; i < IMG_WID * IMG_HEI; i++) begin
      int x, y;
      x = i % IMG_WID;
      y = i / IMG_WID;
      if (x == 100 && y == 100) drive(1'b1, 1'b0, 8'hA0, 1'b1);
      else if (x == 240 && y == 40) drive(1'b1, 1'b0, 8'h55, 1'b1);
      else drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drain();
    checks++;
    assert (n_out - n0 == IMG_WID * IMG_HEI) else begin
      failures++;
      $error("FAIL frame_count obs=%0d exp=%0d", n_out - n0, IMG_WID * IMG_HEI);
    end

    // Both counters wrapped: the next pixel without fst must be (0,0).
    drive(1'b1, 1'b0, 8'h10, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drain();

    // Random gaps with a mid-frame resync.
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 3) != 0) || i == 0 || i == 700;
      drive(rv, i == 0 || i == 700, 8'($urandom_range(0, 255)), 1'b0);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drain();

    // Reset with pixels in both pipeline stages.
    drive(1'b1, 1'b1, 8'h21, 1'b0);
    drive(1'b1, 1'b0, 8'h22, 1'b0);
    drive(1'b1, 1'b0, 8'h23, 1'b0);
    @(posedge clk);
    #2;
    bus.vld_i = 1'b0;
    bus.fst_i = 1'b0;
    rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_adr_q.delete();
    exp_out_q.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      assert ({bus.cmf_rd_en_o, bus.ul_vld_o, bus.ur_vld_o, bus.bl_vld_o, bus.br_vld_o} === 5'b0)
      else begin
        failures++;
        $error("FAIL post_reset_idle obs=%b exp=0",
               {bus.cmf_rd_en_o, bus.ul_vld_o, bus.ur_vld_o, bus.bl_vld_o, bus.br_vld_o});
      end
    end

    // Fresh frame after reset, crossing one row boundary.
    drive(1'b1, 1'b1, 8'h10, 1'b1);
    for (int i = 1; i < 300; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
